// File: rtl/mux8_rr_sched_pkg.sv
// rtl/mux8_rr_sched_pkg.sv - shared constants, FSM state type and one-hot helper for mux8_rr_sched
package mux8_sched_pkg;

    localparam int NREQ = 8;
    localparam int SELW = 3;
    localparam int DW   = 16;

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    // Grant / ack vector for a single requester index.
    function automatic logic [NREQ-1:0] onehot8(input logic [SELW-1:0] sel);
        return NREQ'(1) << sel;
    endfunction

endpackage

// File: rtl/mux8_rr_sched_if.sv
// rtl/mux8_rr_sched_if.sv - request/mux/output handshake bundle between scheduler and its environment
interface mux8_rr_sched_if;
    import mux8_sched_pkg::*;

    logic [NREQ-1:0] REQ;
    logic [SELW-1:0] S;
    logic [DW-1:0]   Y;
    logic [NREQ-1:0] GNT;
    logic [NREQ-1:0] ACK;
    logic [DW-1:0]   DOUT;
    logic [SELW-1:0] DSRC;
    logic            DVLD;
    logic            RDY;

    modport master (
        input  REQ, Y, RDY,
        output S, GNT, ACK, DOUT, DSRC, DVLD
    );

    modport slave (
        output REQ, Y, RDY,
        input  S, GNT, ACK, DOUT, DSRC, DVLD
    );

endinterface

// File: rtl/mux8_rr_sched_pick.sv
// rtl/mux8_rr_sched_pick.sv - combinational round-robin picker, first set request after ptr
module rr_pick8 (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic       any,
    output logic [2:0] idx
);

    // Walk offsets from farthest to nearest so the nearest set bit after ptr wins.
    always_comb begin
        any = 1'b0;
        idx = 3'd0;
        for (int i = 8; i >= 1; i--) begin
            if (req[ptr + 3'(i)]) begin
                any = 1'b1;
                idx = ptr + 3'(i);
            end
        end
    end

endmodule

// File: rtl/mux8_rr_sched.sv
// rtl/mux8_rr_sched.sv - round-robin burst scheduler for a shared 8x16 mux; MUX8_SCHED_PRI0_EN gives requester 0 strict priority
module mux8_rr_sched #(
    parameter int BURST = 4,
    parameter int DW    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    mux8_rr_sched_if.master  bus
);
    import mux8_sched_pkg::*;

    localparam int CW = $clog2(BURST + 1);

    state_t          state, state_nx;
    logic [2:0]      ptr;
    logic [2:0]      sel_q;
    logic [7:0]      gnt_q;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   dout_q;
    logic [2:0]      dsrc_q;
    logic            dvld_q;

    logic            pick_any;
    logic [2:0]      pick_idx;
    logic            win_any;
    logic [2:0]      win_idx;
    logic            pri0_burst;
    logic            req_sel;
    logic            take;
    logic            last;
    logic            rel;

    rr_pick8 u_pick (
        .req (bus.REQ),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

`ifdef MUX8_SCHED_PRI0_EN
    assign win_any    = bus.REQ[0] | pick_any;
    assign win_idx    = bus.REQ[0] ? 3'd0 : pick_idx;
    assign pri0_burst = (sel_q == 3'd0);
`else
    assign win_any    = pick_any;
    assign win_idx    = pick_idx;
    assign pri0_burst = 1'b0;
`endif

    // Transfer and release qualifiers for the current grant; ACK strobes in the same cycle.
    always_comb begin
        req_sel  = bus.REQ[sel_q];
        take     = (state == XFER) && req_sel && (!dvld_q || bus.RDY);
        last     = take && !pri0_burst && (cnt == CW'(BURST - 1));
        rel      = (state == XFER) && (last || !req_sel);
        bus.ACK  = take ? onehot8(sel_q) : 8'h00;
        state_nx = state;
        case (state)
            IDLE:    if (win_any) state_nx = XFER;
            XFER:    if (rel)     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    // Grant, select, burst counter and round-robin pointer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sel_q <= 3'd0;
            gnt_q <= 8'h00;
            cnt   <= '0;
            ptr   <= 3'd7;
        end else if (state == IDLE) begin
            if (win_any) begin
                sel_q <= win_idx;
                gnt_q <= onehot8(win_idx);
                cnt   <= '0;
            end
        end else begin
            if (take && !pri0_burst) cnt <= cnt + 1'b1;
            if (rel) begin
                gnt_q <= 8'h00;
                if (!pri0_burst) ptr <= sel_q;
            end
        end
    end

    // Registered output stage; the held word survives until the consumer takes it.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q <= '0;
            dsrc_q <= 3'd0;
            dvld_q <= 1'b0;
        end else if (take) begin
            dout_q <= bus.Y;
            dsrc_q <= sel_q;
            dvld_q <= 1'b1;
        end else if (dvld_q && bus.RDY) begin
            dvld_q <= 1'b0;
        end
    end

    assign bus.S    = sel_q;
    assign bus.GNT  = gnt_q;
    assign bus.DOUT = dout_q;
    assign bus.DSRC = dsrc_q;
    assign bus.DVLD = dvld_q;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// tb/tb_mux8_rr_sched.sv - directed self-checking bench for mux8_rr_sched
module tb_mux8_rr_sched;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    mux8_rr_sched_if bus ();

    mux8_rr_sched #(.BURST(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [15:0] base  [8];
    logic [15:0] src_n [8];
    logic [18:0] acc   [$];
    logic [7:0]  gtr   [16];
    logic [7:0]  atr   [16];
    int checks = 0;
    int errors = 0;

    assign bus.Y = base[bus.S] + src_n[bus.S];

    always @(posedge CLK) begin
        for (int i = 0; i < 8; i++) begin
            if (RST)             src_n[i] <= 16'h0000;
            else if (bus.ACK[i]) src_n[i] <= src_n[i] + 16'h0001;
        end
    end

    always @(negedge CLK) begin
        if (!RST && bus.DVLD && bus.RDY) acc.push_back({bus.DSRC, bus.DOUT});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] acc_at(input int i);
        return (i < acc.size()) ? acc[i] : 19'h7FFFF;
    endfunction

    function automatic logic [18:0] wd(input logic [2:0] src, input logic [15:0] w);
        return {src, w};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) base[i] = 16'(i) << 12;
        base[2] = 16'hA000;
        base[5] = 16'hB000;
        bus.REQ = 8'h00;
        bus.RDY = 1'b1;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        // idle after reset
        repeat (5) smp();
        check("rst_gnt",  bus.GNT,  8'h00);
        check("rst_ack",  bus.ACK,  8'h00);
        check("rst_dvld", bus.DVLD, 1'b0);
        check("rst_s",    bus.S,    3'd0);
        check("rst_dsrc", bus.DSRC, 3'd0);

        // two requesters alternate in bursts of 4
        tick();
        acc.delete();
        bus.REQ = 8'h24;
        for (int k = 0; k < 12; k++) begin
            smp();
            gtr[k] = bus.GNT;
            atr[k] = bus.ACK;
        end
        check("rr_gnt0",  gtr[0],  8'h00);
        check("rr_gnt1",  gtr[1],  8'h04);
        check("rr_ack1",  atr[1],  8'h04);
        check("rr_gnt4",  gtr[4],  8'h04);
        check("rr_gap5",  gtr[5],  8'h00);
        check("rr_gnt6",  gtr[6],  8'h20);
        check("rr_gnt9",  gtr[9],  8'h20);
        check("rr_gap10", gtr[10], 8'h00);
        check("rr_gnt11", gtr[11], 8'h04);
        check("rr_cnt",   acc.size(), 8);
        for (int i = 0; i < 4; i++) begin
            check("rr_w2", acc_at(i),     wd(3'd2, 16'hA000 + 16'(i)));
            check("rr_w5", acc_at(4 + i), wd(3'd5, 16'hB000 + 16'(i)));
        end
        tick();
        bus.REQ = 8'h00;
        repeat (4) smp();

        // downstream stall holds the word, resume loses nothing
        tick();
        acc.delete();
        bus.REQ = 8'h08;
        smp();
        smp();
        check("st_gnt", bus.GNT, 8'h08);
        check("st_ack", bus.ACK, 8'h08);
        tick();
        bus.RDY = 1'b0;
        smp();
        check("st_dvld2", bus.DVLD, 1'b1);
        check("st_ack2",  bus.ACK,  8'h00);
        repeat (3) smp();
        check("st_dout5", bus.DOUT, 16'h3000);
        check("st_ack5",  bus.ACK,  8'h00);
        check("st_dvld5", bus.DVLD, 1'b1);
        check("st_none",  acc.size(), 0);
        tick();
        bus.RDY = 1'b1;
        repeat (3) smp();
        tick();
        bus.REQ = 8'h00;
        repeat (3) smp();
        check("st_cnt", acc.size(), 4);
        for (int i = 0; i < 4; i++) check("st_w", acc_at(i), wd(3'd3, 16'h3000 + 16'(i)));

        // requester drops early, pointer moves to it
        tick();
        acc.delete();
        bus.REQ = 8'h40;
        smp();
        smp();
        check("dr_gnt1", bus.GNT, 8'h40);
        smp();
        tick();
        bus.REQ = 8'h81;
        smp();
        check("dr_gnt3", bus.GNT, 8'h40);
        check("dr_ack3", bus.ACK, 8'h00);
        smp();
        check("dr_gnt4", bus.GNT, 8'h00);
        smp();
        check("dr_gnt5", bus.GNT, 8'h80);
        tick();
        bus.REQ = 8'h00;
        repeat (4) smp();
        check("dr_w0", acc_at(0), wd(3'd6, 16'h6000));
        check("dr_w1", acc_at(1), wd(3'd6, 16'h6001));
        check("dr_w2", acc_at(2), wd(3'd7, 16'h7000));

        // asynchronous reset mid-burst
        tick();
        bus.REQ = 8'h10;
        repeat (3) smp();
        check("ar_pre", bus.GNT, 8'h10);
        #2;
        RST = 1'b1;
        bus.REQ = 8'hFF;
        #1;
        check("ar_gnt",  bus.GNT,  8'h00);
        check("ar_ack",  bus.ACK,  8'h00);
        check("ar_dvld", bus.DVLD, 1'b0);
        check("ar_dout", bus.DOUT, 16'h0000);
        check("ar_s",    bus.S,    3'd0);
        check("ar_dsrc", bus.DSRC, 3'd0);
        #1;
        RST = 1'b0;
        smp();
        check("ar_first", bus.GNT, 8'h01);
        tick();
        bus.REQ = 8'h00;
        repeat (6) smp();

        // requester 0 versus requester 4 from a fresh reset
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        bus.REQ = 8'h11;
`ifdef MUX8_SCHED_PRI0_EN
        for (int k = 0; k < 7; k++) begin
            smp();
            gtr[k] = bus.GNT;
        end
        tick();
        bus.REQ = 8'h10;
        for (int k = 7; k < 10; k++) begin
            smp();
            gtr[k] = bus.GNT;
        end
        check("p0_gnt1", gtr[1], 8'h01);
        check("p0_gnt6", gtr[6], 8'h01);
        check("p0_gnt7", gtr[7], 8'h01);
        check("p0_gap8", gtr[8], 8'h00);
        check("p0_gnt9", gtr[9], 8'h10);
`else
        for (int k = 0; k < 10; k++) begin
            smp();
            gtr[k] = bus.GNT;
        end
        check("p0_gnt1", gtr[1], 8'h01);
        check("p0_gnt4", gtr[4], 8'h01);
        check("p0_gap5", gtr[5], 8'h00);
        check("p0_gnt6", gtr[6], 8'h10);
`endif
        tick();
        bus.REQ = 8'h00;
        repeat (4) smp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux8_rr_sched.md
Name: mux8_rr_sched

Overview:
- Round-robin scheduler sharing one 8-input x 16-bit word multiplexer among 8 requesters.
- Arbitrates REQ, drives the mux select S, captures the mux output Y into a registered output stage, and issues per-requester ACK strobes.
- Grants are held for bursts of up to BURST words.
- Sits between the 8 data sources (via the 8x16 mux) and a single downstream consumer with a valid/ready handshake.

Parameters:
- BURST, 4, maximum words transferred per grant; legal range 1..255.
- DW, 16, data width; fixed by the mux and not to be overridden.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- REQ  input  8  per-requester request; bit i high means source i has a word presented on mux input Di.
- S  output  3  select for the 8x16 mux; registered.
- Y  input  16  mux output, combinational from S.
- GNT  output  8  one-hot grant; all zero when idle; registered.
- ACK  output  8  one-cycle strobe; bit i high means the word on Di was taken this cycle, and the source advances next cycle.
- DOUT  output  16  registered output word.
- DSRC  output  3  source index of DOUT.
- DVLD  output  1  DOUT valid.
- RDY  input  1  downstream accepts DOUT when DVLD && RDY.

Behaviour:
- Reset: state IDLE, S=0, GNT=0, ACK=0, DOUT=0, DSRC=0, DVLD=0, PTR=7 (so the first search starts at requester 0), CNT=0. Reset mid-burst aborts the burst; any word held in DOUT is discarded.
- States: IDLE and XFER.
- IDLE:
  - If REQ!=0, pick the first set bit searching from (PTR+1) mod 8 upward with wrap-around.
  - Register S=winner, GNT=onehot(winner), CNT=0, then go to XFER.
  - If REQ==0, stay in IDLE.
  - Latency: REQ rise to GNT is 1 cycle.
- XFER, transfer condition: T = REQ[S] && (!DVLD || RDY).
  - On T: DOUT<=Y, DSRC<=S, DVLD<=1, ACK[S]=1 (combinational strobe in the same cycle; all other ACK bits 0), CNT<=CNT+1.
- XFER, release: on the cycle where T && CNT==BURST-1, or where REQ[S]==0.
  - GNT<=0, PTR<=S, go to IDLE.
  - There is always at least one IDLE cycle between grants.
  - S holds its value while idle.
- Output stage:
  - If DVLD && RDY && !T, then DVLD<=0.
  - DOUT and DSRC are stable while DVLD && !RDY.
  - Throughput: 1 word/cycle within a burst while RDY is held high.
- REQ changes on non-granted bits during XFER have no effect. REQ may drop in the same cycle as its last ACK; the block then releases on the next cycle.
- BURST=1: every grant moves exactly one word (2 cycles per word including IDLE).
- CNT width is clog2(BURST+1). CNT never wraps because the release condition fires first.

Optional Feature:
- MUX8_SCHED_PRI0_EN defined: requester 0 has strict priority.
  - In IDLE, REQ[0] wins regardless of PTR.
  - A burst from requester 0 is not limited by BURST; it ends only when REQ[0] drops.
  - PTR is not updated after a requester-0 grant.
- Not defined: pure round-robin for all 8 requesters, as described under Behaviour.

Decomposition:
- Package mux8_sched_pkg:
  - NREQ=8, SELW=3, DW=16.
  - State enum {IDLE, XFER}.
  - Function onehot8(sel).
- One sub-module: rr_pick8, a combinational round-robin picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
  - Instantiated once in the top level.

Test Plan:
- After reset, REQ=8'h00 for 5 cycles -> GNT=0, ACK=0, DVLD=0, S=0, DSRC=0.
- REQ=8'h24, RDY=1, D2=16'hA000+n, D5=16'hB000+n, BURST=4 -> grant 2 for 4 words A000..A003 on DOUT with DSRC=2, then 1 IDLE cycle, then grant 5 for B000..B003, then grant 2 again.
- REQ=8'h08, RDY held low after the first word -> DVLD=1, DOUT frozen, no further ACK[3]. Raising RDY resumes at 1 word/cycle with no word lost or duplicated.
- Granted requester 6 drops REQ[6] after 2 words (BURST=4) -> release after the 2nd word, GNT=0, PTR=6; the next winner among REQ=8'h81 is 7.
- RST asserted mid-burst, asynchronously between clock edges -> all outputs reach their reset values immediately. After release, REQ=8'hFF is granted to 0 first.
- With MUX8_SCHED_PRI0_EN defined, REQ=8'h11 -> requester 0 wins every arbitration, and its burst continues past BURST until REQ[0] drops; requester 4 is served only after that.
